// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: four-state grant FSM with tenure timeout and post-timeout lockout.
// Define ARB_ROUND_ROBIN_EN to alternate priority on contention; otherwise master 1 always wins.
module bus_arbiter #(
    parameter int SLAVE_LEN = 2,
    parameter int TIMEOUT   = 4095
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req1,
    input  logic                 req2,
    input  logic                 done1,
    input  logic                 done2,
    input  logic [SLAVE_LEN-1:0] slave1,
    input  logic [SLAVE_LEN-1:0] slave2,
    output logic                 grant1,
    output logic                 grant2,
    output logic [SLAVE_LEN-1:0] slave_sel,
    output logic                 timeout1,
    output logic                 timeout2
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT1  = 2'd1;
    localparam logic [1:0] GRANT2  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [1:0]           grant_reg, grant_next;
    logic [SLAVE_LEN-1:0] sel_reg, sel_next;
    logic [1:0]           to_reg, to_next;
    logic [1:0]           lock_reg, lock_next;
    logic [1:0]           req, done, elig;
    logic                 favour2;

    // Bit 0 is master 1, bit 1 is master 2 throughout.
    assign req  = {req2, req1};
    assign done = {done2, done1};
    assign elig = req & ~lock_reg;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio2_reg;

    // Whoever is granted now yields priority to the other master next contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio2_reg <= 1'b0;
        end else if (state_reg == IDLE && grant_next != 2'b00) begin
            prio2_reg <= grant_next[0];
        end
    end

    assign favour2 = prio2_reg;
`else
    assign favour2 = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        grant_next = 2'b00;
        sel_next   = '0;
        to_next    = 2'b00;
        case (state_reg)
            IDLE: begin
                if (elig[1] && (!elig[0] || favour2)) begin
                    state_next = GRANT2;
                    grant_next = 2'b10;
                    sel_next   = slave2;
                end else if (elig[0]) begin
                    state_next = GRANT1;
                    grant_next = 2'b01;
                    sel_next   = slave1;
                end
            end
            GRANT1: begin
                // A done in the final tenure cycle takes precedence over the timeout.
                if (done[0] || !req[0]) begin
                    state_next = RELEASE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RELEASE;
                    to_next    = 2'b01;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    grant_next = 2'b01;
                    sel_next   = sel_reg;
                end
            end
            GRANT2: begin
                if (done[1] || !req[1]) begin
                    state_next = RELEASE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RELEASE;
                    to_next    = 2'b10;
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    grant_next = 2'b10;
                    sel_next   = sel_reg;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A timed-out master stays locked out until its request is seen low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lock
            assign lock_next[gi] = to_next[gi] | (lock_reg[gi] & req[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            grant_reg <= 2'b00;
            sel_reg   <= '0;
            to_reg    <= 2'b00;
            lock_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            to_reg    <= to_next;
            lock_reg  <= lock_next;
        end
    end

    assign grant1    = grant_reg[0];
    assign grant2    = grant_reg[1];
    assign slave_sel = sel_reg;
    assign timeout1  = to_reg[0];
    assign timeout2  = to_reg[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic checked against a tenure-level reference model.
module tb_bus_arbiter;

    localparam int SL = 2;
    localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req1, req2, done1, done2;
    logic [SL-1:0] slave1, slave2;
    logic          grant1, grant2;
    logic [SL-1:0] slave_sel;
    logic          timeout1, timeout2;

    bus_arbiter #(.SLAVE_LEN(SL), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req1      (req1),
        .req2      (req2),
        .done1     (done1),
        .done2     (done2),
        .slave1    (slave1),
        .slave2    (slave2),
        .grant1    (grant1),
        .grant2    (grant2),
        .slave_sel (slave_sel),
        .timeout1  (timeout1),
        .timeout2  (timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the bus, for how many cycles, and who is locked out.
    int            m_owner;
    int            m_held;
    bit            m_gap;
    bit            m_lock [1:2];
    int            m_next_rr;
    logic [SL-1:0] m_sel;
    bit            m_to [1:2];

    task automatic model_reset();
        m_owner   = 0;
        m_held    = 0;
        m_gap     = 1'b0;
        m_lock[1] = 1'b0;
        m_lock[2] = 1'b0;
        m_next_rr = 1;
        m_sel     = '0;
        m_to[1]   = 1'b0;
        m_to[2]   = 1'b0;
    endtask

    task automatic model_step();
        bit            rq [1:2];
        bit            dn [1:2];
        logic [SL-1:0] sv [1:2];
        int            x;
        bit            e1, e2;
        rq[1] = req1;  rq[2] = req2;
        dn[1] = done1; dn[2] = done2;
        sv[1] = slave1; sv[2] = slave2;
        m_to[1] = 1'b0;
        m_to[2] = 1'b0;
        if (m_owner != 0) begin
            x = m_owner;
            if (dn[x] || !rq[x]) begin
                m_owner = 0;
                m_gap   = 1'b1;
            end else if (m_held == TO) begin
                m_owner   = 0;
                m_gap     = 1'b1;
                m_to[x]   = 1'b1;
                m_lock[x] = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            e1 = rq[1] && !m_lock[1];
            e2 = rq[2] && !m_lock[2];
            x  = 0;
            if (e1 && e2)  x = RR ? m_next_rr : 1;
            else if (e1)   x = 1;
            else if (e2)   x = 2;
            if (x != 0) begin
                m_owner   = x;
                m_held    = 1;
                m_sel     = sv[x];
                m_next_rr = 3 - x;
            end
        end
        for (int i = 1; i <= 2; i++) if (!rq[i]) m_lock[i] = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic eg1, input logic eg2,
                              input logic [SL-1:0] esel, input logic et1, input logic et2);
        tests++;
        if ({grant1, grant2, slave_sel, timeout1, timeout2} !== {eg1, eg2, esel, et1, et2}) begin
            fails++;
            $display("[TB] FAIL %s: got grant=%b%b sel=%0d to=%b%b, required grant=%b%b sel=%0d to=%b%b",
                     name, grant1, grant2, slave_sel, timeout1, timeout2, eg1, eg2, esel, et1, et2);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock: model advances on the same edge as the DUT; outputs are read at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("reset_state", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct packed {
        logic          rs;
        logic [3:0]    rd;   // {req1, req2, done1, done2}
        logic [SL-1:0] s1;
        logic [SL-1:0] s2;
        logic [1:0]    g;    // {grant1, grant2}
        logic [SL-1:0] sel;
        logic [1:0]    to;   // {timeout1, timeout2}
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rs, input logic [3:0] rd, input logic [SL-1:0] s1,
                       input logic [SL-1:0] s2, input logic [1:0] g, input logic [SL-1:0] sel,
                       input logic [1:0] to);
        vec_t v;
        v.rs = rs; v.rd = rd; v.s1 = s1; v.s2 = s2; v.g = g; v.sel = sel; v.to = to;
        vq.push_back(v);
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b0;
        req1 = 1'b0; req2 = 1'b0; done1 = 1'b0; done2 = 1'b0;
        slave1 = '0; slave2 = '0;
        model_reset();

        // Single request, done on 5th grant cycle, ignored slave change and foreign done.
        add(1'b1, 4'b1000, 2'd2, 2'd0, 2'b10, 2'd2, 2'b00);
        add(1'b0, 4'b1000, 2'd3, 2'd0, 2'b10, 2'd2, 2'b00);
        add(1'b0, 4'b1000, 2'd3, 2'd0, 2'b10, 2'd2, 2'b00);
        add(1'b0, 4'b1000, 2'd3, 2'd0, 2'b10, 2'd2, 2'b00);
        add(1'b0, 4'b1000, 2'd3, 2'd0, 2'b10, 2'd2, 2'b00);
        add(1'b0, 4'b1010, 2'd3, 2'd0, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b0000, 2'd0, 2'd0, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b0100, 2'd0, 2'd1, 2'b01, 2'd1, 2'b00);
        add(1'b0, 4'b1100, 2'd0, 2'd1, 2'b01, 2'd1, 2'b00);
        add(1'b0, 4'b1110, 2'd0, 2'd1, 2'b01, 2'd1, 2'b00);
        add(1'b0, 4'b1000, 2'd0, 2'd1, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b1000, 2'd0, 2'd1, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b1000, 2'd0, 2'd1, 2'b10, 2'd0, 2'b00);
        add(1'b0, 4'b0000, 2'd0, 2'd1, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b0000, 2'd0, 2'd1, 2'b00, 2'd0, 2'b00);
        // Contention, each tenure ended by done after 3 grant cycles.
        add(1'b1, 4'b1100, 2'd1, 2'd2, 2'b10, 2'd1, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, 2'b10, 2'd1, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, 2'b10, 2'd1, 2'b00);
        add(1'b0, 4'b1110, 2'd1, 2'd2, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, RR ? 2'b01 : 2'b10, RR ? 2'd2 : 2'd1, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, RR ? 2'b01 : 2'b10, RR ? 2'd2 : 2'd1, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, RR ? 2'b01 : 2'b10, RR ? 2'd2 : 2'd1, 2'b00);
        add(1'b0, RR ? 4'b1101 : 4'b1110, 2'd1, 2'd2, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b1100, 2'd1, 2'd2, 2'b10, 2'd1, 2'b00);
        add(1'b0, 4'b0000, 2'd1, 2'd2, 2'b00, 2'd0, 2'b00);
        add(1'b0, 4'b0000, 2'd1, 2'd2, 2'b00, 2'd0, 2'b00);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rs) do_reset();
            {req1, req2, done1, done2} = vq[i].rd;
            slave1 = vq[i].s1;
            slave2 = vq[i].s2;
            tick();
            check_outs($sformatf("vec%0d", i), vq[i].g[1], vq[i].g[0], vq[i].sel, vq[i].to[1], vq[i].to[0]);
            $display("[TB] vec %0d req=%b%b done=%b%b -> grant=%b%b sel=%0d to=%b%b",
                     i, req1, req2, done1, done2, grant1, grant2, slave_sel, timeout1, timeout2);
        end
        {req1, req2, done1, done2} = 4'b0000;

        // Timeout on master 2, then lockout until req2 is seen low.
        do_reset();
        req2 = 1'b1; slave2 = 2'd3;
        tick();
        n = 0;
        while (grant2 === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check_val("timeout_tenure_len", n, TO);
        check_outs("timeout2_pulse", 1'b0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        check_outs("timeout2_one_cycle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant2 !== 1'b0) bad++;
        end
        check_val("lockout_no_regrant", bad, 0);
        req2 = 1'b0;
        tick();
        req2 = 1'b1;
        tick();
        check_outs("regrant_after_drop", 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        $display("[TB] timeout seq: tenure=%0d cycles, regrant grant2=%b", n, grant2);
        req2 = 1'b0;
        tick();
        tick();

        // done1 arriving in the last allowed grant cycle beats the timeout.
        do_reset();
        req1 = 1'b1; slave1 = 2'd1;
        tick();
        repeat (7) tick();
        check_outs("grant1_cycle8", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        check_outs("collision_no_timeout", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        check_outs("collision_gap", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        check_outs("collision_no_lockout", 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        $display("[TB] collision seq: done in cycle %0d, timeout1 stayed low", TO);
        req1 = 1'b0;
        tick();
        tick();

        // Asynchronous reset in the third grant cycle.
        do_reset();
        req1 = 1'b1; slave1 = 2'd2;
        tick();
        tick();
        tick();
        check_outs("grant1_cycle3", 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset_drop", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        req1 = 1'b0; req2 = 1'b1; slave2 = 2'd1;
        tick();
        check_outs("grant2_after_reset", 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        $display("[TB] reset seq: grant dropped asynchronously, grant2=%b after release", grant2);
        req2 = 1'b0;
        tick();
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 9) == 0) req1 = ~req1;
            if ($urandom_range(0, 9) == 0) req2 = ~req2;
            done1  = ($urandom_range(0, 11) == 0);
            done2  = ($urandom_range(0, 11) == 0);
            slave1 = SL'($urandom);
            slave2 = SL'($urandom);
            tick();
            check_outs($sformatf("rand%0d", c), m_owner == 1, m_owner == 2,
                       (m_owner != 0) ? m_sel : '0, m_to[1], m_to[2]);
            if (grant1 === 1'b1 && grant2 === 1'b1) bad++;
        end
        check_val("rand_mutual_exclusion", bad, 0);
        $display("[TB] random phase: 3000 cycles compared against model");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
